// File: rtl/fwd_credit_adapter.sv
// fwd_credit_adapter: bridges a packet forwarder's request/ack read interface
// onto a P3-style packet memory port. Reads are credit limited so every issued
// read has a guaranteed slot in the local read-data FIFO. Packet handshake:
// IDLE offers the packet, GRANTED issues reads, DRAIN waits for all data to
// leave before pulsing done.
// Optional feature: define FWD_CREDIT_ADAPTER_PKTCNT_EN to add a 32-bit
// completed-packet counter output (pkt_count).
module fwd_credit_adapter #(
  parameter int PACKMEM_ADDR_WIDTH = 8,
  parameter int PACKMEM_DATA_WIDTH = 64,
  parameter int PLEN_WIDTH         = 32,
  parameter int ADDR_SHIFT         = 1,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  // forwarder side
  input  logic [PACKMEM_ADDR_WIDTH-1:0]            fwd_addr,
  input  logic                                     fwd_rd_en,
  input  logic                                     fwd_done,
  input  logic                                     rdy_for_fwd_ack,
  input  logic                                     fwd_rd_data_rdy,
  output logic                                     rdy_for_fwd,
  output logic                                     fwd_rd_ok,
  output logic [PACKMEM_DATA_WIDTH-1:0]            fwd_rd_data,
  output logic                                     fwd_rd_data_vld,
  output logic [PLEN_WIDTH-1:0]                    fwd_bytes,
  // packet memory (P3) side
  output logic [PACKMEM_ADDR_WIDTH+ADDR_SHIFT-1:0] addr,
  output logic                                     rd_en,
  output logic                                     done,
  output logic                                     rdy_ack,
  input  logic                                     rdy,
  input  logic                                     rd_data_vld,
  input  logic [PACKMEM_DATA_WIDTH-1:0]            rd_data,
  input  logic [PLEN_WIDTH-1:0]                    bytes
`ifdef FWD_CREDIT_ADAPTER_PKTCNT_EN
  ,
  output logic [31:0]                              pkt_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);  // counter width, holds 0..FIFO_DEPTH
  localparam int PW = $clog2(FIFO_DEPTH);      // FIFO pointer width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PACKMEM_DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [CW:0] credit_used;
  logic        credit_ok;
  logic        push, pop;
  logic        drained;
  logic        grant;

  // Reads in flight plus words already buffered must never exceed the FIFO,
  // so a returning word always has room.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok   = (credit_used < (CW+1)'(FIFO_DEPTH));

  // Data returning with nothing outstanding is stale (e.g. after a reset
  // mid-packet) and is dropped.
  assign push    = rd_data_vld & (outstanding != '0) & ~rst;
  assign pop     = fwd_rd_data_vld & fwd_rd_data_rdy;
  assign drained = (outstanding == '0) & (fifo_count == '0);

  assign addr            = {fwd_addr, {ADDR_SHIFT{1'b0}}};
  assign rd_en           = fwd_rd_en & fwd_rd_ok;
  assign fwd_rd_data_vld = ~rst & (fifo_count != '0);
  assign fwd_rd_data     = mem[rd_ptr];
  assign grant           = rdy & rdy_for_fwd_ack;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake/credit outputs; everything held low in reset.
  always_comb begin
    state_nxt   = state;
    rdy_for_fwd = 1'b0;
    rdy_ack     = 1'b0;
    fwd_rd_ok   = 1'b0;
    unique case (state)
      IDLE: begin
        rdy_for_fwd = rdy;
        rdy_ack     = grant;
        if (grant) state_nxt = GRANTED;
      end
      GRANTED: begin
        fwd_rd_ok = credit_ok;
        if (fwd_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drained) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      rdy_for_fwd = 1'b0;
      rdy_ack     = 1'b0;
      fwd_rd_ok   = 1'b0;
    end
  end

  // Outstanding read tracker: issue increments, accepted return decrements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({rd_en, push})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while empty so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rd_data;
  end

  // Packet length captured at the grant handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        fwd_bytes <= '0;
    else if (grant && state == IDLE) fwd_bytes <= bytes;
  end

  // One-cycle done pulse coincident with the return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= 1'b0;
    else     done <= (state == DRAIN) & drained;
  end

`ifdef FWD_CREDIT_ADAPTER_PKTCNT_EN
  // Completed-packet counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pkt_count <= '0;
    else if (done) pkt_count <= pkt_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fwd_credit_adapter.sv
// Directed self-checking bench for fwd_credit_adapter (default parameters).
module tb_fwd_credit_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fwd_addr;
  logic        fwd_rd_en, fwd_done, rdy_for_fwd_ack, fwd_rd_data_rdy;
  logic        rdy_for_fwd, fwd_rd_ok, fwd_rd_data_vld;
  logic [63:0] fwd_rd_data;
  logic [31:0] fwd_bytes;
  logic [8:0]  addr;
  logic        rd_en, done, rdy_ack;
  logic        rdy, rd_data_vld;
  logic [63:0] rd_data;
  logic [31:0] bytes;
`ifdef FWD_CREDIT_ADAPTER_PKTCNT_EN
  logic [31:0] pkt_count;
`endif

  int errors = 0;
  int checks = 0;
  int n_rd;

  always #5 clk = ~clk;

  fwd_credit_adapter dut (
    .clk(clk), .rst(rst),
    .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en), .fwd_done(fwd_done),
    .rdy_for_fwd_ack(rdy_for_fwd_ack), .fwd_rd_data_rdy(fwd_rd_data_rdy),
    .rdy_for_fwd(rdy_for_fwd), .fwd_rd_ok(fwd_rd_ok), .fwd_rd_data(fwd_rd_data),
    .fwd_rd_data_vld(fwd_rd_data_vld), .fwd_bytes(fwd_bytes),
    .addr(addr), .rd_en(rd_en), .done(done), .rdy_ack(rdy_ack),
    .rdy(rdy), .rd_data_vld(rd_data_vld), .rd_data(rd_data), .bytes(bytes)
`ifdef FWD_CREDIT_ADAPTER_PKTCNT_EN
    , .pkt_count(pkt_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fwd_addr = 8'h00; fwd_rd_en = 1'b1; fwd_done = 1'b0;
    rdy_for_fwd_ack = 1'b1; fwd_rd_data_rdy = 1'b0; rdy = 1'b1;
    rd_data_vld = 1'b0; rd_data = 64'h0; bytes = 32'h40;

    // Reset: all handshake outputs forced low regardless of inputs.
    step(); step();
    chk("rst_rdy_for_fwd", rdy_for_fwd, 0);
    chk("rst_rdy_ack", rdy_ack, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_fwd_rd_ok", fwd_rd_ok, 0);
    chk("rst_done", done, 0);
    chk("rst_fwd_rd_data_vld", fwd_rd_data_vld, 0);
    chk("rst_fwd_bytes", fwd_bytes, 0);
`ifdef FWD_CREDIT_ADAPTER_PKTCNT_EN
    chk("rst_pkt_count", pkt_count, 0);
`endif

    // IDLE offer without ack.
    rst = 1'b0; fwd_rd_en = 1'b0; rdy_for_fwd_ack = 1'b0;
    #1;
    chk("idle_rdy_for_fwd", rdy_for_fwd, 1);
    chk("idle_rdy_ack_noack", rdy_ack, 0);
    step(); step();

    // Ack: combinational rdy_ack, length latched next cycle.
    rdy_for_fwd_ack = 1'b1;
    #1;
    chk("grant_rdy_ack", rdy_ack, 1);
    step();
    rdy_for_fwd_ack = 1'b0;
    #1;
    chk("granted_fwd_bytes", fwd_bytes, 32'h40);
    chk("granted_rdy_for_fwd", rdy_for_fwd, 0);
    chk("granted_rdy_ack", rdy_ack, 0);
    chk("granted_fwd_rd_ok", fwd_rd_ok, 1);

    // Six back-to-back reads with the consumer stalled: only 4 credits.
    n_rd = 0;
    fwd_addr = 8'h12;
    for (int i = 0; i < 6; i++) begin
      fwd_rd_en = 1'b1;
      #1;
      if (i == 0) begin
        chk("addr_shift", addr, 9'h024);
        chk("first_rd_en", rd_en, 1);
      end
      n_rd += int'(rd_en);
      step();
    end
    fwd_rd_en = 1'b0;
    #1;
    chk("credit_rd_en_count", n_rd, 4);
    chk("credit_exhausted_ok", fwd_rd_ok, 0);

    // One word returns: still no credit (moved from outstanding to FIFO).
    rd_data_vld = 1'b1; rd_data = 64'hA0;
    step();
    rd_data_vld = 1'b0;
    #1;
    chk("fifo_vld", fwd_rd_data_vld, 1);
    chk("fifo_head", fwd_rd_data, 64'hA0);
    chk("still_no_credit", fwd_rd_ok, 0);

    // Pop frees one credit.
    fwd_rd_data_rdy = 1'b1;
    step();
    fwd_rd_data_rdy = 1'b0;
    #1;
    chk("pop_frees_credit", fwd_rd_ok, 1);
    chk("fifo_empty_after_pop", fwd_rd_data_vld, 0);

    // fwd_done together with a read: read honoured, then DRAIN.
    fwd_done = 1'b1; fwd_rd_en = 1'b1;
    #1;
    chk("done_with_read_rd_en", rd_en, 1);
    step();
    fwd_done = 1'b0;
    #1;
    chk("drain_rd_en_blocked", rd_en, 0);
    chk("drain_no_offer", rdy_for_fwd, 0);
    fwd_rd_en = 1'b0;

    // Return the 4 outstanding words with the consumer draining.
    fwd_rd_data_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_data_vld = 1'b1; rd_data = 64'hB0 + 64'(i);
      step();
      chk("drain_head", fwd_rd_data, 64'hB0 + 64'(i));
      chk("drain_no_done", done, 0);
    end
    rd_data_vld = 1'b0;
    step();                               // last word popped
    chk("drain_empty", fwd_rd_data_vld, 0);
    chk("done_not_yet", done, 0);
    step();
    chk("done_pulse", done, 1);
    chk("back_to_idle", rdy_for_fwd, 1);
`ifdef FWD_CREDIT_ADAPTER_PKTCNT_EN
    chk("pkt_count_one", pkt_count, 1);
`endif
    step();
    chk("done_one_cycle", done, 0);

    // Stray return data in IDLE is discarded.
    rd_data_vld = 1'b1; rd_data = 64'hDEAD;
    step();
    rd_data_vld = 1'b0;
    #1;
    chk("idle_stray_discard", fwd_rd_data_vld, 0);

    // New packet, 3 reads in flight, then reset.
    fwd_rd_data_rdy = 1'b0; bytes = 32'h80; rdy_for_fwd_ack = 1'b1;
    step();
    rdy_for_fwd_ack = 1'b0;
    #1;
    chk("pkt2_fwd_bytes", fwd_bytes, 32'h80);
    fwd_rd_en = 1'b1;
    step(); step(); step();
    rst = 1'b1; rdy_for_fwd_ack = 1'b1;
    #1;
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_fwd_rd_ok", fwd_rd_ok, 0);
    chk("midrst_rdy_ack", rdy_ack, 0);
    step();
    rst = 1'b0; fwd_rd_en = 1'b0; rdy_for_fwd_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_data_vld = 1'b1; rd_data = 64'hC0 + 64'(i);
      step();
      chk("late_data_discard", fwd_rd_data_vld, 0);
      chk("late_data_no_done", done, 0);
    end
    rd_data_vld = 1'b0;
    step();
    chk("postrst_no_done", done, 0);
    chk("postrst_fwd_bytes", fwd_bytes, 0);
    chk("postrst_idle_offer", rdy_for_fwd, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_credit_adapter.md
FWD_CREDIT_ADAPTER -- requirements
Module: fwd_credit_adapter

Interface
REQ-001 Parameter PACKMEM_ADDR_WIDTH, default 8, forwarder word-address width.
REQ-002 Parameter PACKMEM_DATA_WIDTH, default 64, read-data width.
REQ-003 Parameter PLEN_WIDTH, default 32, packet byte-length width.
REQ-004 Parameter ADDR_SHIFT, default 1, number of zero LSBs appended to fwd_addr to form addr.
REQ-005 Parameter FIFO_DEPTH, default 4, read-data FIFO depth and read-credit limit (power of 2, >=2).
REQ-006 Port clk  in  1  sole clock; all state on rising edge.
REQ-007 Port rst  in  1  reset, asynchronous, active-high.
REQ-008 Port fwd_addr  in  PACKMEM_ADDR_WIDTH  forwarder read word address.
REQ-009 Port fwd_rd_en  in  1  forwarder read request.
REQ-010 Port fwd_done  in  1  forwarder finished issuing reads for current packet.
REQ-011 Port rdy_for_fwd_ack  in  1  forwarder accepts offered packet.
REQ-012 Port fwd_rd_data_rdy  in  1  forwarder can take a data word.
REQ-013 Port rdy_for_fwd  out  1  packet available to forwarder.
REQ-014 Port fwd_rd_ok  out  1  a read issued this cycle will be accepted.
REQ-015 Port fwd_rd_data  out  PACKMEM_DATA_WIDTH  FIFO head data.
REQ-016 Port fwd_rd_data_vld  out  1  FIFO non-empty.
REQ-017 Port fwd_bytes  out  PLEN_WIDTH  latched packet length.
REQ-018 Port addr  out  PACKMEM_ADDR_WIDTH+ADDR_SHIFT  P3 read address.
REQ-019 Port rd_en, done, rdy_ack  out  1 each  P3 read strobe, done pulse, ready ack.
REQ-020 Port rdy, rd_data_vld  in  1 each; rd_data  in  PACKMEM_DATA_WIDTH; bytes  in  PLEN_WIDTH  P3 side.

Function
REQ-021 FSM states IDLE, GRANTED, DRAIN; reset state IDLE.
REQ-022 IDLE: rdy_for_fwd = rdy; rdy_ack = rdy & rdy_for_fwd_ack (combinational); on that condition latch bytes into fwd_bytes, go GRANTED.
REQ-023 GRANTED/DRAIN: rdy_for_fwd = 0, rdy_ack = 0.
REQ-024 Credit: fwd_rd_ok = (state==GRANTED) & (outstanding + fifo_count < FIFO_DEPTH).
REQ-025 rd_en = fwd_rd_en & fwd_rd_ok; fwd_rd_en without fwd_rd_ok is dropped, no side effect.
REQ-026 addr = {fwd_addr, ADDR_SHIFT zero bits}, combinational, always driven.
REQ-027 outstanding counter (width clog2(FIFO_DEPTH+1)): +1 on rd_en, -1 on accepted rd_data_vld, unchanged when both same cycle.
REQ-028 rd_data_vld with outstanding==0 is discarded (no FIFO push, no counter change).
REQ-029 Accepted rd_data_vld pushes rd_data; data visible on fwd_rd_data one cycle later (registered FIFO).
REQ-030 Pop on fwd_rd_data_vld & fwd_rd_data_rdy; simultaneous push/pop keeps fifo_count; credit rule guarantees no overflow.
REQ-031 fwd_done in GRANTED -> DRAIN; fwd_done in IDLE/DRAIN ignored; fwd_done with fwd_rd_en same cycle: read honoured per REQ-025, then DRAIN.
REQ-032 DRAIN: when outstanding==0 and FIFO empty, done pulses high exactly one cycle, next state IDLE.
REQ-033 done is registered; never high outside the DRAIN->IDLE transition cycle.

Reset
REQ-034 While rst high: state IDLE, counters 0, FIFO empty, fwd_bytes 0, rdy_for_fwd/rdy_ack/rd_en/done/fwd_rd_ok/fwd_rd_data_vld forced 0.
REQ-035 Reset mid-packet aborts without done; late rd_data_vld after release is discarded per REQ-028.

Configuration
REQ-036 Macro FWD_CREDIT_ADAPTER_PKTCNT_EN defined: extra output pkt_count [31:0], reset 0, +1 per done pulse, wraps 0xFFFFFFFF->0.
REQ-037 Macro undefined: pkt_count port and counter absent; all other behaviour identical.

Verification
REQ-038 rdy=1, bytes=0x40, ack at cycle 5 -> rdy_ack high cycle 5, fwd_bytes=0x40 from cycle 6, rdy_for_fwd=0 from cycle 6.
REQ-039 fwd_addr=0x12, ADDR_SHIFT=1, read in GRANTED -> addr=0x024, rd_en=1 same cycle.
REQ-040 FIFO_DEPTH=4, fwd_rd_data_rdy=0, 6 back-to-back reads -> exactly 4 rd_en, fwd_rd_ok=0 after 4th until a pop.
REQ-041 fwd_done with 2 outstanding, data returns cycles +3,+4, drained immediately -> done one-cycle pulse after FIFO empties, state IDLE, pkt_count=1 with macro.
REQ-042 rst asserted with 3 outstanding, then 3 rd_data_vld after release -> all discarded, fwd_rd_data_vld stays 0, no done.
